// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch front end.
package stopwatch_pkg;

    // 20 ms at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    localparam logic [1:0] VIEW_LIVE = 2'd0;
    localparam logic [1:0] VIEW_LAP1 = 2'd1;
    localparam logic [1:0] VIEW_LAP2 = 2'd2;
    localparam logic [1:0] VIEW_LAP3 = 2'd3;

    typedef enum logic {
        LAP_IDLE  = 1'b0,
        LAP_ARMED = 1'b1
    } lap_state_t;

endpackage

// File: rtl/debounce.sv
// Synchronises one raw push-button, debounces it and emits a one-cycle
// pulse on each accepted rising edge.
module debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk_50M,
    input  logic reset_n,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Delayed copy of the accepted level for rising-edge detection.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable;
        end
    end

    // Presses only; releases produce nothing.
    assign press = stable & ~stable_d;

endmodule

// File: rtl/button_conditioner.sv
// Stopwatch button front end: run/pause toggle, lap-capture handshake
// with the 100 Hz tick, and one-hot lap-view select.
module button_conditioner
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk_50M,
    input  logic reset_n,
    input  logic btn_pause,
    input  logic btn_lap,
    input  logic btn_view,
    input  logic tick_100,
    output logic pause,
    output logic lap,
    output logic lap1,
    output logic lap2,
    output logic lap3
);

    logic       press_pause;
    logic       press_lap;
    logic       press_view;
    lap_state_t lap_state;
    logic [1:0] view;
    logic [1:0] view_next;

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_pause (
        .clk_50M(clk_50M),
        .reset_n(reset_n),
        .btn    (btn_pause),
        .press  (press_pause)
    );

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_lap (
        .clk_50M(clk_50M),
        .reset_n(reset_n),
        .btn    (btn_lap),
        .press  (press_lap)
    );

    debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_view (
        .clk_50M(clk_50M),
        .reset_n(reset_n),
        .btn    (btn_view),
        .press  (press_view)
    );

    // Run/pause toggle.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            pause <= 1'b0;
        end else if (press_pause) begin
            pause <= ~pause;
        end
    end

    // Lap request held until the next count tick; extra presses while armed are dropped.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            lap_state <= LAP_IDLE;
            lap       <= 1'b0;
        end else begin
            unique case (lap_state)
                LAP_IDLE: begin
                    // A tick in the same cycle as the press is not consumed.
                    if (press_lap) begin
                        lap_state <= LAP_ARMED;
                        lap       <= 1'b1;
                    end
                end
                LAP_ARMED: begin
                    if (tick_100) begin
                        lap_state <= LAP_IDLE;
                        lap       <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Next view index, wrapping from lap 3 back to live.
    always_comb begin
        view_next = view;
        if (press_view) begin
            view_next = view + 2'd1;
        end
    end

    // View register plus registered one-hot decode so outputs stay flop-driven.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            view <= VIEW_LIVE;
            lap1 <= 1'b0;
            lap2 <= 1'b0;
            lap3 <= 1'b0;
        end else begin
            view <= view_next;
            lap1 <= (view_next == VIEW_LAP1);
            lap2 <= (view_next == VIEW_LAP2);
            lap3 <= (view_next == VIEW_LAP3);
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with a short debounce time.
module tb_button_conditioner;

    localparam int unsigned D  = 4;
    localparam int unsigned HL = D + 2;

    logic clk_50M = 1'b0;
    logic reset_n;
    logic btn_pause;
    logic btn_lap;
    logic btn_view;
    logic tick_100;
    logic pause;
    logic lap;
    logic lap1;
    logic lap2;
    logic lap3;

    int checks = 0;
    int errors = 0;

    // Expected {pause, lap, lap1, lap2, lap3} after each clock edge.
    logic [4:0] exp_q[$];

    // Reference model state.
    bit [2:0] hist[$];   // raw samples per edge, bit0=pause bit1=lap bit2=view
    bit       m_stable[3];
    bit       m_rose[3];
    bit       m_pause;
    bit       m_armed;
    int       m_view;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (4)
    ) dut (
        .clk_50M  (clk_50M),
        .reset_n  (reset_n),
        .btn_pause(btn_pause),
        .btn_lap  (btn_lap),
        .btn_view (btn_view),
        .tick_100 (tick_100),
        .pause    (pause),
        .lap      (lap),
        .lap1     (lap1),
        .lap2     (lap2),
        .lap3     (lap3)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < int'(HL); i++) hist.push_back(3'b000);
        for (int b = 0; b < 3; b++) begin
            m_stable[b] = 1'b0;
            m_rose[b]   = 1'b0;
        end
        m_pause = 1'b0;
        m_armed = 1'b0;
        m_view  = 0;
    endtask

    function automatic logic [4:0] model_out();
        return {m_pause, m_armed, m_view == 1, m_view == 2, m_view == 3};
    endfunction

    // One clock edge: advance the model with the inputs the DUT just sampled.
    task automatic cycle();
        bit [2:0] raw;
        bit       differ;
        @(posedge clk_50M);
        if (!reset_n) begin
            model_reset();
        end else begin
            raw = {btn_view, btn_lap, btn_pause};
            // Presses accepted on the previous edge act now.
            if (m_rose[0]) m_pause = !m_pause;
            if (!m_armed) begin
                if (m_rose[1]) m_armed = 1'b1;
            end else if (tick_100) begin
                m_armed = 1'b0;
            end
            if (m_rose[2]) m_view = (m_view + 1) % 4;
            hist.push_back(raw);
            // Level accepted once the D synchronised samples before this edge all disagree.
            for (int b = 0; b < 3; b++) begin
                differ = 1'b1;
                for (int i = 1; i <= int'(D); i++) begin
                    if (hist[i][b] == m_stable[b]) differ = 1'b0;
                end
                m_rose[b] = differ && !m_stable[b];
                if (differ) m_stable[b] = !m_stable[b];
            end
            void'(hist.pop_front());
        end
        exp_q.push_back(model_out());
        #1;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    always @(negedge clk_50M) begin
        logic [4:0] e;
        logic [4:0] a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {pause, lap, lap1, lap2, lap3};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs @%0t: pause,lap,lap1,lap2,lap3 got %b required %b",
                         $time, a, e);
            end
        end
    end

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_pause = v;
            1:       btn_lap   = v;
            default: btn_view  = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        repeat (8) cycle();
        set_btn(b, 1'b0);
        repeat (8) cycle();
    endtask

    task automatic tick_pulse();
        tick_100 = 1'b1;
        cycle();
        tick_100 = 1'b0;
        repeat (3) cycle();
    endtask

    initial begin
        model_reset();
        reset_n   = 1'b0;
        btn_pause = 1'b1;
        btn_lap   = 1'b1;
        btn_view  = 1'b1;
        tick_100  = 1'b0;

        // Reset with buttons held, then release: one press each after the debounce time.
        repeat (5) cycle();
        reset_n = 1'b1;
        repeat (20) cycle();
        btn_pause = 1'b0;
        btn_lap   = 1'b0;
        btn_view  = 1'b0;
        repeat (12) cycle();
        tick_pulse();

        // Bouncy pause press, then a too-short pulse.
        repeat (5) begin
            btn_pause = 1'b1;
            cycle();
            btn_pause = 1'b0;
            cycle();
        end
        btn_pause = 1'b1;
        repeat (12) cycle();
        btn_pause = 1'b0;
        repeat (10) cycle();
        btn_pause = 1'b1;
        repeat (3) cycle();
        btn_pause = 1'b0;
        repeat (10) cycle();

        // Lap handshake: long armed period, tick, then a double press while armed.
        press(1);
        repeat (50) cycle();
        tick_pulse();
        press(1);
        press(1);
        tick_pulse();

        // Lap press landing on the same cycle as a tick.
        btn_lap = 1'b1;
        repeat (6) cycle();
        tick_100 = 1'b1;
        cycle();
        tick_100 = 1'b0;
        repeat (4) cycle();
        btn_lap = 1'b0;
        repeat (20) cycle();
        tick_pulse();

        // View wrap over five presses.
        repeat (5) press(2);

        // Randomised buttons and ticks.
        repeat (300) begin
            int len;
            btn_pause = 1'($urandom_range(0, 1));
            btn_lap   = 1'($urandom_range(0, 1));
            btn_view  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            repeat (len) begin
                tick_100 = ($urandom_range(0, 15) == 0);
                cycle();
            end
        end
        btn_pause = 1'b0;
        btn_lap   = 1'b0;
        btn_view  = 1'b0;
        tick_100  = 1'b0;
        repeat (12) cycle();

        // Build up armed / paused / view 2, then reset asynchronously mid-cycle.
        for (int n = 0; n < 4 && m_view != 2; n++) press(2);
        if (!m_pause) press(0);
        if (!m_armed) press(1);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pause, lap, lap1, lap2, lap3} !== 5'b00000) begin
            errors++;
            $display("FAIL async_reset: outputs got %b required 00000",
                     {pause, lap, lap1, lap2, lap3});
        end
        model_reset();
        exp_q[exp_q.size() - 1] = 5'b00000;
        cycle();
        reset_n = 1'b1;
        repeat (10) cycle();
        press(2);

        @(negedge clk_50M);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
